// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS-lite fetch front end.
//   npc_sel_e  : next-PC source select (SEQ / BRANCH / JUMP / JREG)
//   pc_state_e : fetch state machine (BOOT / RUN / FAULT)
//   PC_RESET_DEFAULT : PC loaded on reset, maps to instruction memory word 0
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JREG   = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc.sv
// npc: purely combinational next-PC calculator.
//   pc         in  32  current PC
//   npc_sel    in   2  next-PC source (npc_sel_e)
//   br_taken   in   1  branch condition, only used for NPC_BRANCH
//   imm16      in  16  signed branch offset in words
//   target26   in  26  jump target field
//   reg_target in  32  rs value for jr (low bits passed through)
//   npc        out 32  computed next PC, modulo 2^32
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  npc_sel_e    npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] reg_target,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;

  assign seq_pc = pc + 32'd4;
  // Word offset sign-extended and scaled to bytes.
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = seq_pc;
    case (npc_sel)
      NPC_SEQ:    npc = seq_pc;
      NPC_BRANCH: npc = br_taken ? (seq_pc + br_off) : seq_pc;
      NPC_JUMP:   npc = {seq_pc[31:28], target26, 2'b00};
      NPC_JREG:   npc = reg_target;
      default:    npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: instruction-fetch front end for the single-cycle MIPS-lite datapath.
// Holds the PC, a BOOT bubble after reset, stall hold and a fetch counter.
//   clk, rst_n   clock; synchronous active-low reset
//   stall        hold PC and counter this cycle
//   npc_sel      next-PC source (00 SEQ, 01 BRANCH, 10 JUMP, 11 JREG)
//   br_taken, imm16, target26, reg_target : next-PC operands
//   pc, pc_plus4 current PC and jal link value
//   im_addr      instruction memory word address, pc[IM_AW+1:2]
//   fetch_valid  instruction memory output is a real instruction
//   fetch_count  instructions accepted since reset
//   fault        (only with PC_UNIT_RANGE_CHECK_EN) out-of-window or
//                misaligned next PC was refused; sticky until reset
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IM_AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [1:0]       npc_sel,
  input  logic             br_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [31:0]      reg_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [IM_AW-1:0] im_addr,
  output logic             fetch_valid,
  output logic [31:0]      fetch_count
`ifdef PC_UNIT_RANGE_CHECK_EN
  ,
  output logic             fault
`endif
);

  pc_state_e   state;
  logic [31:0] npc_val;

  npc u_npc (
    .pc         (pc),
    .npc_sel    (npc_sel_e'(npc_sel)),
    .br_taken   (br_taken),
    .imm16      (imm16),
    .target26   (target26),
    .reg_target (reg_target),
    .npc        (npc_val)
  );

  assign pc_plus4 = pc + 32'd4;
  assign im_addr  = pc[IM_AW+1:2];

`ifdef PC_UNIT_RANGE_CHECK_EN
  // Compare in 33 bits so the window top cannot overflow.
  localparam logic [32:0] PC_LO = {1'b0, PC_RESET};
  localparam logic [32:0] PC_HI = PC_LO + (33'd4 << IM_AW);

  logic npc_bad;
  assign npc_bad = (npc_val[1:0] != 2'b00) ||
                   ({1'b0, npc_val} < PC_LO) ||
                   ({1'b0, npc_val} >= PC_HI);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= PC_RESET;
      state       <= BOOT;
      fetch_count <= '0;
      fetch_valid <= 1'b0;
`ifdef PC_UNIT_RANGE_CHECK_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
`ifdef PC_UNIT_RANGE_CHECK_EN
            if (npc_bad) begin
              state       <= FAULT;
              fetch_valid <= 1'b0;
              fault       <= 1'b1;
            end else begin
              pc          <= npc_val;
              fetch_count <= fetch_count + 32'd1;
            end
`else
            pc          <= npc_val;
            fetch_count <= fetch_count + 32'd1;
`endif
          end
        end
        // FAULT: everything frozen until reset.
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        fv;
    logic [7:0]  ia;
    logic [31:0] p4;
    logic        flt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic [31:0] reg_target = '0;
  logic [31:0] pc, pc_plus4, fetch_count;
  logic [7:0]  im_addr;
  logic        fetch_valid;
  logic        flt_obs;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // reference model state: 0 BOOT, 1 RUN, 2 FAULT
  int          m_state = 0;
  logic [31:0] m_pc = 32'h3000;
  logic [31:0] m_cnt = '0;
  logic        m_flt = 1'b0;
  obs_t        sb[$];

  pc_unit #(.PC_RESET(32'h0000_3000), .IM_AW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .target26    (target26),
    .reg_target  (reg_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .im_addr     (im_addr),
    .fetch_valid (fetch_valid),
    .fetch_count (fetch_count)
`ifdef PC_UNIT_RANGE_CHECK_EN
    ,
    .fault       (flt_obs)
`endif
  );

`ifndef PC_UNIT_RANGE_CHECK_EN
  assign flt_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.pc = pc; o.cnt = fetch_count; o.fv = fetch_valid;
    o.ia = im_addr; o.p4 = pc_plus4; o.flt = flt_obs;
    return o;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expectation,
  // then step past the edge.
  task automatic cycle(input logic r, input logic s, input logic [1:0] sel,
                       input logic br, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] rt);
    logic [31:0] np;
    logic signed [31:0] off;
    obs_t e;
    rst_n = r; stall = s; npc_sel = sel; br_taken = br;
    imm16 = imm; target26 = tgt; reg_target = rt;
    if (!r) begin
      m_state = 0; m_pc = 32'h3000; m_cnt = '0; m_flt = 1'b0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1 && !s) begin
      off = $signed(imm);
      case (sel)
        2'd0: np = m_pc + 4;
        2'd1: np = br ? m_pc + 4 + 32'(off * 4) : m_pc + 4;
        2'd2: np = ((m_pc + 4) & 32'hF000_0000) | ({6'b0, tgt} * 4);
        default: np = rt;
      endcase
`ifdef PC_UNIT_RANGE_CHECK_EN
      if (np[1:0] != 2'b00 || np < 32'h3000 || np >= 32'h3400) begin
        m_state = 2; m_flt = 1'b1;
      end else begin
        m_pc = np; m_cnt = m_cnt + 1;
      end
`else
      m_pc = np; m_cnt = m_cnt + 1;
`endif
    end
    e.pc = m_pc; e.cnt = m_cnt; e.fv = (m_state == 1);
    e.ia = m_pc[9:2]; e.p4 = m_pc + 4; e.flt = m_flt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic seq_cycle(input logic s);
    cycle(1'b1, s, 2'd0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset;
    obs_t e, o;
    cycle(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset_sb: got %h need %h", o, e);
    end
    vectors++;
    if (pc !== 32'h3000 || fetch_valid !== 1'b0 || fetch_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: got pc=%h fv=%b cnt=%0d need pc=3000 fv=0 cnt=0",
               pc, fetch_valid, fetch_count);
    end
  endtask

  task automatic test_seq;
    obs_t e, o;
    logic [31:0] want_pc[3];
    want_pc[0] = 32'h3000; want_pc[1] = 32'h3004; want_pc[2] = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      seq_cycle(1'b0);
      e = sb.pop_front(); o = observe();
      vectors++;
      if (o !== e || pc !== want_pc[i] || im_addr !== 8'(i) ||
          fetch_count !== 32'(i) || fetch_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL seq_%0d: got pc=%h ia=%h cnt=%0d fv=%b need pc=%h ia=%0d cnt=%0d fv=1",
                 i, pc, im_addr, fetch_count, fetch_valid, want_pc[i], i, i);
      end
    end
  endtask

  task automatic test_branch;
    obs_t e, o;
    cycle(1'b1, 1'b0, 2'd1, 1'b1, 16'hFFFE, '0, '0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e || pc !== 32'h3004) begin
      miscompares++;
      $display("FAIL branch_taken: got pc=%h need %h", pc, 32'h3004);
    end
    seq_cycle(1'b0);
    void'(sb.pop_front());
    cycle(1'b1, 1'b0, 2'd1, 1'b0, 16'hFFFE, '0, '0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e || pc !== 32'h300C) begin
      miscompares++;
      $display("FAIL branch_not_taken: got pc=%h need %h", pc, 32'h300C);
    end
    seq_cycle(1'b0);
    void'(sb.pop_front());
  endtask

  task automatic test_jump;
    obs_t e, o;
    cycle(1'b1, 1'b0, 2'd2, 1'b0, '0, 26'h0000C10, '0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e || pc !== 32'h3040 || im_addr !== 8'h10) begin
      miscompares++;
      $display("FAIL jump: got pc=%h ia=%h need pc=3040 ia=10", pc, im_addr);
    end
    vectors++;
    if (pc_plus4 !== 32'h3044) begin
      miscompares++;
      $display("FAIL jal_link: got %h need %h", pc_plus4, 32'h3044);
    end
    cycle(1'b1, 1'b0, 2'd3, 1'b0, '0, '0, 32'h3014);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e || pc !== 32'h3014) begin
      miscompares++;
      $display("FAIL jreg: got pc=%h need %h", pc, 32'h3014);
    end
  endtask

  task automatic test_stall;
    obs_t e, o;
    logic [31:0] cnt0;
    for (int i = 0; i < 3; i++) begin
      seq_cycle(1'b0);
      void'(sb.pop_front());
    end
    cnt0 = fetch_count;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 2'd2, 1'b0, '0, 26'h0000C14, '0);
      e = sb.pop_front(); o = observe();
      vectors++;
      if (o !== e || pc !== 32'h3020 || fetch_count !== cnt0) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got pc=%h cnt=%0d need pc=3020 cnt=%0d",
                 i, pc, fetch_count, cnt0);
      end
    end
    cycle(1'b1, 1'b0, 2'd2, 1'b0, '0, 26'h0000C14, '0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e || pc !== 32'h3050 || fetch_count !== cnt0 + 1) begin
      miscompares++;
      $display("FAIL stall_release: got pc=%h cnt=%0d need pc=3050 cnt=%0d",
               pc, fetch_count, cnt0 + 1);
    end
  endtask

  task automatic test_reset_in_stall;
    obs_t e, o;
    cycle(1'b0, 1'b1, 2'd2, 1'b0, '0, 26'h0000C14, '0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e || pc !== 32'h3000 || fetch_count !== 32'd0 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got pc=%h cnt=%0d fv=%b need pc=3000 cnt=0 fv=0",
               pc, fetch_count, fetch_valid);
    end
    // BOOT leaves regardless of stall; then the stall holds pc at reset value.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 2'd2, 1'b0, '0, 26'h0000C14, '0);
      e = sb.pop_front(); o = observe();
      vectors++;
      if (o !== e || pc !== 32'h3000 || fetch_valid !== 1'b1 || fetch_count !== 32'd0) begin
        miscompares++;
        $display("FAIL boot_under_stall_%0d: got pc=%h fv=%b cnt=%0d need pc=3000 fv=1 cnt=0",
                 i, pc, fetch_valid, fetch_count);
      end
    end
    seq_cycle(1'b0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e || pc !== 32'h3004 || fetch_count !== 32'd1) begin
      miscompares++;
      $display("FAIL after_boot_seq: got pc=%h cnt=%0d need pc=3004 cnt=1", pc, fetch_count);
    end
  endtask

  task automatic test_range;
    obs_t e, o;
    logic [31:0] cnt0;
    cnt0 = fetch_count;
    cycle(1'b1, 1'b0, 2'd3, 1'b0, '0, '0, 32'h3402);
    e = sb.pop_front(); o = observe();
    vectors++;
`ifdef PC_UNIT_RANGE_CHECK_EN
    if (o !== e || flt_obs !== 1'b1 || pc !== 32'h3004 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL range_fault: got flt=%b pc=%h fv=%b need flt=1 pc=3004 fv=0",
               flt_obs, pc, fetch_valid);
    end
    for (int i = 0; i < 2; i++) begin
      seq_cycle(1'b0);
      e = sb.pop_front(); o = observe();
      vectors++;
      if (o !== e || pc !== 32'h3004 || fetch_count !== cnt0 || fetch_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fault_frozen_%0d: got pc=%h cnt=%0d fv=%b need pc=3004 cnt=%0d fv=0",
                 i, pc, fetch_count, fetch_valid, cnt0);
      end
    end
`else
    if (o !== e || pc !== 32'h3402 || im_addr !== 8'h00 || fetch_count !== cnt0 + 1) begin
      miscompares++;
      $display("FAIL range_wrap: got pc=%h ia=%h cnt=%0d need pc=3402 ia=00 cnt=%0d",
               pc, im_addr, fetch_count, cnt0 + 1);
    end
`endif
    cycle(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
    e = sb.pop_front(); o = observe();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL range_reset: got %h need %h", o, e);
    end
  endtask

  task automatic test_random;
    obs_t e, o;
    logic [1:0]  sel;
    logic [31:0] rt;
    for (int i = 0; i < 60; i++) begin
      sel = 2'($urandom_range(0, 3));
      rt = (i == 30) ? 32'hFFFF_FFFC : 32'h3000 + ($urandom_range(0, 255) * 4);
      cycle(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) == 0), sel,
            1'($urandom), 16'($urandom_range(0, 16)) - 16'd8,
            26'h0000C00 + 26'($urandom_range(0, 255)), rt);
      e = sb.pop_front(); o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random_%0d: got pc=%h cnt=%0d fv=%b ia=%h p4=%h flt=%b need pc=%h cnt=%0d fv=%b ia=%h p4=%h flt=%b",
                 i, o.pc, o.cnt, o.fv, o.ia, o.p4, o.flt, e.pc, e.cnt, e.fv, e.ia, e.p4, e.flt);
      end
    end
  endtask

  initial begin
    test_reset;
    test_seq;
    test_branch;
    test_jump;
    test_stall;
    test_reset_in_stall;
    test_range;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
